// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: CH_NUM single-cycle strobes from one clock, each with
// its own divide ratio and start phase, started and stopped under software control.
module clk_en_sched #(
   parameter int CH_NUM  = 4,
   parameter int DIV_W   = 16,
   parameter int DEF_DIV = 9,
   parameter int CH_W    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_vld,
   output logic              cfg_rdy,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_phase,
   output logic              cfg_err,
   input  logic              run_req,
   input  logic              stop_req,
   output logic              running,
   output logic [CH_NUM-1:0] clk_en,
   output logic [15:0]       epoch_cnt
);

   typedef enum logic [1:0] {IDLE, SYNC, RUN, STOP} state_t;

   state_t                         r_state;
   logic [CH_NUM-1:0][DIV_W-1:0]   r_div;
   logic [CH_NUM-1:0][DIV_W-1:0]   r_phase;
   logic [CH_NUM-1:0][DIV_W-1:0]   r_cnt;
   logic [CH_NUM-1:0]              r_en;
   logic                           r_err;
   logic [15:0]                    r_epoch;

   logic             w_cfg_fire;
   logic             w_ch_ok;
   logic [DIV_W-1:0] w_phase;
   logic             w_cnt0_zero;

   assign cfg_rdy     = (r_state == IDLE);
   assign running     = (r_state != IDLE);
   assign w_cfg_fire  = cfg_vld && cfg_rdy;
   assign w_ch_ok     = (32'(cfg_ch) < 32'(CH_NUM));
   // A phase beyond the period would only delay the first strobe past a full cycle.
   assign w_phase     = (cfg_phase > cfg_div) ? cfg_div : cfg_phase;
   assign w_cnt0_zero = (r_cnt[0] == '0);
   assign clk_en      = r_en;
   assign cfg_err     = r_err;
   assign epoch_cnt   = r_epoch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_err   <= 1'b0;
         r_epoch <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_cfg_fire && !w_ch_ok) r_err <= 1'b1;
               if (run_req) begin
                  r_state <= SYNC;
                  r_err   <= 1'b0;
                  r_epoch <= '0;
               end
            end
            SYNC: r_state <= RUN;
            RUN: begin
               if (w_cnt0_zero) r_epoch <= r_epoch + 16'd1;
               if (stop_req) r_state <= STOP;
            end
            STOP: begin
               // Leave on the edge that launches the final channel-0 strobe.
               if (w_cnt0_zero) begin
                  r_epoch <= r_epoch + 16'd1;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div   <= {CH_NUM{DIV_W'(DEF_DIV)}};
         r_phase <= '0;
         r_cnt   <= '0;
         r_en    <= '0;
      end else begin
         for (int i = 0; i < CH_NUM; i++) begin
            if (w_cfg_fire && (32'(cfg_ch) == i)) begin
               r_div[i]   <= cfg_div;
               r_phase[i] <= w_phase;
            end
            case (r_state)
               SYNC: begin
                  r_cnt[i] <= r_phase[i];
                  r_en[i]  <= 1'b0;
               end
               RUN, STOP: begin
                  if (r_cnt[i] == '0) begin
                     r_en[i]  <= 1'b1;
                     r_cnt[i] <= r_div[i];
                  end else begin
                     r_en[i]  <= 1'b0;
                     r_cnt[i] <= r_cnt[i] - DIV_W'(1);
                  end
               end
               default: r_en[i] <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_clk_en_sched.sv
// Directed bench for clk_en_sched: table of channel configurations checked cycle by
// cycle against the strobe timing formula, plus stop, stall, error and reset sequences.
module tb_clk_en_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_vld, run_req, stop_req;
   logic [1:0]  cfg_ch;
   logic [15:0] cfg_div, cfg_phase;
   logic        cfg_rdy, cfg_err, running;
   logic [3:0]  clk_en;
   logic [15:0] epoch_cnt;
   logic        cfg_rdy3, cfg_err3, running3;
   logic [2:0]  clk_en3;
   logic [15:0] epoch_cnt3;

   always #5 clk = ~clk;

   clk_en_sched #(.CH_NUM(4), .DIV_W(16), .DEF_DIV(9), .CH_W(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .cfg_ch(cfg_ch),
      .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err), .run_req(run_req),
      .stop_req(stop_req), .running(running), .clk_en(clk_en), .epoch_cnt(epoch_cnt));

   // Three-channel copy sharing all inputs: cfg_ch=3 is out of range here.
   clk_en_sched #(.CH_NUM(3), .DIV_W(16), .DEF_DIV(9), .CH_W(2)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy3), .cfg_ch(cfg_ch),
      .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err3), .run_req(run_req),
      .stop_req(stop_req), .running(running3), .clk_en(clk_en3), .epoch_cnt(epoch_cnt3));

   typedef struct packed {
      logic [3:0][15:0] div;
      logic [3:0][15:0] ph;
      logic [3:0][15:0] eph;     // phase after clamping, hand-derived
      logic [15:0]      n;       // RUN cycles observed before stop_req
      logic [15:0]      ep_n;    // epoch_cnt after n cycles
      logic [15:0]      stop_t;  // cycle where running is first seen low
      logic [15:0]      ep_end;  // epoch_cnt after the final strobe
   } row_t;

   row_t             rows [4];
   int               checks = 0;
   int               errors = 0;
   int               t;
   logic [3:0][15:0] cur_div, cur_eph;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d actual=%0h required=%0h", nm, t, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] exp_en(input int tt);
      logic [3:0] e;
      e = '0;
      for (int i = 0; i < 4; i++) begin
         int p, d;
         p = int'(cur_eph[i]);
         d = int'(cur_div[i]) + 1;
         if (tt >= p + 1 && ((tt - p - 1) % d) == 0) e[i] = 1'b1;
      end
      return e;
   endfunction

   task automatic do_cfg(input int ch, input logic [15:0] dv, input logic [15:0] ph);
      cfg_vld = 1'b1; cfg_ch = 2'(ch); cfg_div = dv; cfg_phase = ph;
      tick();
      cfg_vld = 1'b0;
   endtask

   task automatic start_run();
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      chk("sync_running", running, 1);
      chk("epoch_clear", epoch_cnt, 0);
      chk("err_clear", cfg_err, 0);
      chk("err3_clear", cfg_err3, 0);
      tick();
      t = 0;
      chk("t0_en", clk_en, 0);
   endtask

   task automatic run_cycles(input int n);
      logic [3:0] e;
      logic [2:0] e3;
      for (int k = 0; k < n; k++) begin
         tick();
         t++;
         e = exp_en(t);
         e3 = e[2:0];
         chk("run_en", clk_en, e);
         chk("run_en3", clk_en3, e3);
         chk("run_running", running, 1);
         chk("run_rdy", cfg_rdy, 0);
      end
   endtask

   // stop_req (with a simultaneous run_req) issued in the current cycle, both held through STOP.
   task automatic stop_drain(input int stop_t, input int ep_end);
      logic [3:0] e;
      logic       done;
      done = 1'b0;
      stop_req = 1'b1;
      run_req  = 1'b1;
      for (int k = 0; k < 100 && !done; k++) begin
         tick();
         t++;
         e = exp_en(t);
         chk("stop_en", clk_en, e);
         if (!running) begin
            done = 1'b1;
            stop_req = 1'b0;
            run_req  = 1'b0;
         end
      end
      stop_req = 1'b0;
      run_req  = 1'b0;
      chk("stop_done", done, 1);
      chk("stop_time", t, stop_t);
      chk("stop_final_en0", clk_en[0], 1);
      chk("stop_epoch", epoch_cnt, ep_end);
      chk("stop_rdy", cfg_rdy, 1);
      tick();
      chk("idle_en", clk_en, 0);
      chk("idle_en3", clk_en3, 0);
      chk("idle_running", running, 0);
      chk("idle_epoch", epoch_cnt, ep_end);
   endtask

   initial begin
      rows[0].div = {16'd9, 16'd9, 16'd9, 16'd9};
      rows[0].ph  = '0;
      rows[0].eph = '0;
      rows[0].n = 16'd30; rows[0].ep_n = 16'd3; rows[0].stop_t = 16'd41; rows[0].ep_end = 16'd5;
      rows[1] = rows[0];
      rows[1].n = 16'd26; rows[1].ep_n = 16'd3; rows[1].stop_t = 16'd31; rows[1].ep_end = 16'd4;
      rows[2].div = {16'd5, 16'd0, 16'd3, 16'd9};
      rows[2].ph  = {16'd20, 16'd0, 16'd2, 16'd0};
      rows[2].eph = {16'd5, 16'd0, 16'd2, 16'd0};
      rows[2].n = 16'd12; rows[2].ep_n = 16'd2; rows[2].stop_t = 16'd21; rows[2].ep_end = 16'd3;
      rows[3].div = {16'd4, 16'd7, 16'd1, 16'd2};
      rows[3].ph  = {16'd3, 16'd7, 16'd0, 16'd1};
      rows[3].eph = {16'd3, 16'd7, 16'd0, 16'd1};
      rows[3].n = 16'd10; rows[3].ep_n = 16'd3; rows[3].stop_t = 16'd14; rows[3].ep_end = 16'd5;

      t = 0;
      rst_n = 1'b0; cfg_vld = 1'b0; run_req = 1'b0; stop_req = 1'b0;
      cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
      #12;
      chk("rst_rdy", cfg_rdy, 1);
      chk("rst_running", running, 0);
      chk("rst_en", clk_en, 0);
      chk("rst_epoch", epoch_cnt, 0);
      chk("rst_err", cfg_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int r = 0; r < 4; r++) begin
         for (int ch = 0; ch < 4; ch++) do_cfg(ch, rows[r].div[ch], rows[r].ph[ch]);
         cur_div = rows[r].div;
         cur_eph = rows[r].eph;
         start_run();
         run_cycles(int'(rows[r].n));
         chk("epoch_n", epoch_cnt, rows[r].ep_n);
         stop_drain(int'(rows[r].stop_t), int'(rows[r].ep_end));
      end

      // Out-of-range channel on the 3-channel copy; the 4-channel copy accepts it.
      do_cfg(3, 16'd6, 16'd1);
      chk("err3_set", cfg_err3, 1);
      chk("err_main", cfg_err, 0);
      do_cfg(0, 16'd9, 16'd0);
      chk("err3_sticky", cfg_err3, 1);
      cur_div = {16'd6, 16'd7, 16'd1, 16'd9};
      cur_eph = {16'd1, 16'd7, 16'd0, 16'd0};
      start_run();
      run_cycles(15);
      chk("err_run_epoch", epoch_cnt, 2);
      stop_drain(21, 3);

      // Write held through RUN stalls, then lands in the first IDLE cycle.
      start_run();
      cfg_vld = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd4; cfg_phase = 16'd9;
      run_cycles(8);
      stop_drain(11, 2);
      cur_div[1] = 16'd4;
      cur_eph[1] = 16'd4;
      // Write and run_req together: the run uses the new value.
      cfg_ch = 2'd2; cfg_div = 16'd2; cfg_phase = 16'd0; run_req = 1'b1;
      tick();
      cfg_vld = 1'b0; run_req = 1'b0;
      chk("cfgrun_running", running, 1);
      tick();
      t = 0;
      cur_div[2] = 16'd2;
      cur_eph[2] = 16'd0;
      run_cycles(12);
      chk("cfgrun_epoch", epoch_cnt, 2);
      stop_drain(21, 3);

      // Asynchronous reset mid-RUN while a strobe is high.
      start_run();
      run_cycles(4);
      chk("pre_rst_en2", clk_en[2], 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_en", clk_en, 0);
      chk("arst_en3", clk_en3, 0);
      chk("arst_running", running, 0);
      chk("arst_rdy", cfg_rdy, 1);
      chk("arst_epoch", epoch_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_running", running, 0);
      chk("post_rst_err", cfg_err, 0);
      cur_div = {16'd9, 16'd9, 16'd9, 16'd9};
      cur_eph = '0;
      start_run();
      run_cycles(12);
      chk("post_rst_epoch", epoch_cnt, 2);
      stop_drain(21, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
